// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
// States are plain 2-bit constants so older decode/debug logic can compare raw codes.
package fetch_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 16'h0800;
  localparam logic [WORD_W-1:0] RESET_PC_DEF  = 16'h0000;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_WAIT_MEM = 2'd1;
  localparam state_t ST_HOLD     = 2'd2;
  localparam state_t ST_HALTED   = 2'd3;

  // Instructions are two bytes wide; the PC wraps naturally at 16 bits.
  function automatic logic [WORD_W-1:0] pc_plus2(input logic [WORD_W-1:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register holding {instr, pc+2, valid} for the decode stage.
// Flush inserts a bubble and wins over load; with neither asserted the register holds.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic [WORD_W-1:0] next_instr,
  input  logic [WORD_W-1:0] next_pc2,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pc2,
  output logic              valid
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instr <= NOP_INSTR;
      pc2   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= next_instr;
      pc2   <= next_pc2;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, imem request FSM, one-entry skid buffer for words arriving under a
// stall, and a pending-redirect register for branches resolved mid-access.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_haz,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt_id,
  output logic              imem_rd,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_data,
  input  logic              imem_done,
  output logic [WORD_W-1:0] if_id_instr,
  output logic [WORD_W-1:0] if_id_pc2,
  output logic              if_id_valid,
  output logic              halted
);

  state_t            state, state_n;
  logic [WORD_W-1:0] pc, pc_n;
  logic              buf_valid, buf_valid_n;
  logic [WORD_W-1:0] buf_data, buf_data_n;
  logic              pend, pend_n;
  logic [WORD_W-1:0] pend_pc, pend_pc_n;
  logic              ifid_load, ifid_flush;
  logic              fetching, data_present;
  logic [WORD_W-1:0] data_word;

  assign fetching     = (state == ST_RUN) || (state == ST_WAIT_MEM);
  assign data_present = fetching ? imem_done : ((state == ST_HOLD) && buf_valid);
  assign data_word    = (state == ST_HOLD) ? buf_data : imem_data;

  assign imem_rd   = fetching;
  assign imem_addr = pc;
  assign halted    = (state == ST_HALTED);

  // Priority: redirect > halt > pending redirect > stall > normal flow.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    buf_valid_n = buf_valid;
    buf_data_n  = buf_data;
    pend_n      = pend;
    pend_pc_n   = pend_pc;
    ifid_load   = 1'b0;
    ifid_flush  = 1'b0;

    if (state == ST_HALTED) begin
      state_n = ST_HALTED;
    end else if (redirect) begin
      ifid_flush  = 1'b1;
      buf_valid_n = 1'b0;
      // Address must stay stable until the in-flight access completes.
      if ((state == ST_WAIT_MEM) && !imem_done) begin
        pend_n    = 1'b1;
        pend_pc_n = redirect_pc;
      end else begin
        pc_n    = redirect_pc;
        pend_n  = 1'b0;
        state_n = ST_RUN;
      end
    end else if (halt_id) begin
      ifid_flush  = 1'b1;
      buf_valid_n = 1'b0;
      pend_n      = 1'b0;
      state_n     = ST_HALTED;
    end else if (pend) begin
      ifid_flush = 1'b1;
      if (imem_done) begin
        pc_n    = pend_pc;
        pend_n  = 1'b0;
        state_n = ST_RUN;
      end
    end else if (reg_haz) begin
      if (state != ST_HOLD) begin
        if (imem_done) begin
          buf_valid_n = 1'b1;
          buf_data_n  = imem_data;
          state_n     = ST_HOLD;
        end else begin
          state_n = ST_WAIT_MEM;
        end
      end
    end else if (data_present) begin
      ifid_load   = 1'b1;
      pc_n        = pc_plus2(pc);
      buf_valid_n = 1'b0;
      state_n     = ST_RUN;
    end else begin
      ifid_flush = 1'b1;
      state_n    = (state == ST_HOLD) ? ST_RUN : ST_WAIT_MEM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      pc        <= RESET_PC;
      buf_valid <= 1'b0;
      buf_data  <= '0;
      pend      <= 1'b0;
      pend_pc   <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      buf_valid <= buf_valid_n;
      buf_data  <= buf_data_n;
      pend      <= pend_n;
      pend_pc   <= pend_pc_n;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .load      (ifid_load),
    .flush     (ifid_flush),
    .next_instr(data_word),
    .next_pc2  (pc_plus2(pc)),
    .instr     (if_id_instr),
    .pc2       (if_id_pc2),
    .valid     (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; imem returns addr ^ 16'hA5A5 whenever imem_done is high.
// Inputs change and outputs are sampled on the falling edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, reg_haz, redirect, halt_id, imem_done;
  logic [15:0] redirect_pc, imem_data;
  logic        imem_rd, if_id_valid, halted;
  logic [15:0] imem_addr, if_id_instr, if_id_pc2;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign imem_data = imem_addr ^ 16'hA5A5;

  fetch_stage dut (
    .clk(clk), .rst(rst), .reg_haz(reg_haz), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt_id(halt_id), .imem_rd(imem_rd),
    .imem_addr(imem_addr), .imem_data(imem_data), .imem_done(imem_done),
    .if_id_instr(if_id_instr), .if_id_pc2(if_id_pc2), .if_id_valid(if_id_valid),
    .halted(halted)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; reg_haz = 0; redirect = 0; redirect_pc = 16'h0; halt_id = 0; imem_done = 1;
    tick(); tick();
    checks++; if (imem_addr !== 16'h0000) begin fails++; $display("[TB] FAIL reset_addr got %h exp 0000", imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got %b exp 0", if_id_valid); end
    checks++; if (if_id_instr !== 16'h0800) begin fails++; $display("[TB] FAIL reset_instr got %h exp 0800", if_id_instr); end
    checks++; if (if_id_pc2 !== 16'h0000) begin fails++; $display("[TB] FAIL reset_pc2 got %h exp 0000", if_id_pc2); end
    checks++; if (halted !== 1'b0) begin fails++; $display("[TB] FAIL reset_halted got %b exp 0", halted); end
    checks++; if (imem_rd !== 1'b1) begin fails++; $display("[TB] FAIL reset_rd got %b exp 1", imem_rd); end
  endtask

  task automatic test_stream();
    logic [15:0] ep;
    rst = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      ep = 16'(2 * k);
      checks++; if (if_id_valid !== 1'b1 || if_id_pc2 !== ep || if_id_instr !== ((ep - 16'd2) ^ 16'hA5A5))
        begin fails++; $display("[TB] FAIL stream_%0d got v=%b pc2=%h i=%h exp pc2=%h", k, if_id_valid, if_id_pc2, if_id_instr, ep); end
      checks++; if (imem_addr !== ep) begin fails++; $display("[TB] FAIL stream_addr_%0d got %h exp %h", k, imem_addr, ep); end
    end
  endtask

  task automatic test_stall();
    reg_haz = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (if_id_pc2 !== 16'h0008 || if_id_instr !== (16'h0006 ^ 16'hA5A5) || if_id_valid !== 1'b1)
        begin fails++; $display("[TB] FAIL stall_frozen_%0d got pc2=%h i=%h v=%b exp pc2=0008", k, if_id_pc2, if_id_instr, if_id_valid); end
      checks++; if (imem_rd !== 1'b0 || imem_addr !== 16'h0008)
        begin fails++; $display("[TB] FAIL stall_rd_%0d got rd=%b addr=%h exp rd=0 addr=0008", k, imem_rd, imem_addr); end
    end
    reg_haz = 0;
    tick();
    checks++; if (if_id_pc2 !== 16'h000A || if_id_instr !== (16'h0008 ^ 16'hA5A5) || if_id_valid !== 1'b1)
      begin fails++; $display("[TB] FAIL stall_release got pc2=%h i=%h exp pc2=000a i=%h", if_id_pc2, if_id_instr, 16'h0008 ^ 16'hA5A5); end
    checks++; if (imem_addr !== 16'h000A || imem_rd !== 1'b1)
      begin fails++; $display("[TB] FAIL stall_release_addr got %h rd=%b exp 000a rd=1", imem_addr, imem_rd); end
    tick();
    checks++; if (if_id_pc2 !== 16'h000C || if_id_instr !== (16'h000A ^ 16'hA5A5))
      begin fails++; $display("[TB] FAIL stall_next got pc2=%h i=%h exp pc2=000c", if_id_pc2, if_id_instr); end
  endtask

  task automatic test_wait_mem();
    tick(); tick();
    checks++; if (imem_addr !== 16'h0010) begin fails++; $display("[TB] FAIL wait_setup got %h exp 0010", imem_addr); end
    imem_done = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (imem_addr !== 16'h0010 || imem_rd !== 1'b1 || if_id_valid !== 1'b0 || if_id_instr !== 16'h0800)
        begin fails++; $display("[TB] FAIL wait_bubble_%0d got addr=%h rd=%b v=%b i=%h exp 0010 1 0 0800", k, imem_addr, imem_rd, if_id_valid, if_id_instr); end
    end
    imem_done = 1;
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== (16'h0010 ^ 16'hA5A5) || if_id_pc2 !== 16'h0012)
      begin fails++; $display("[TB] FAIL wait_done got v=%b i=%h pc2=%h exp 1 %h 0012", if_id_valid, if_id_instr, if_id_pc2, 16'h0010 ^ 16'hA5A5); end
  endtask

  task automatic test_redirect_wait();
    redirect = 1; redirect_pc = 16'h0020;
    tick();
    checks++; if (imem_addr !== 16'h0020 || if_id_valid !== 1'b0)
      begin fails++; $display("[TB] FAIL redir_run got addr=%h v=%b exp 0020 0", imem_addr, if_id_valid); end
    redirect = 0; imem_done = 0;
    tick();
    redirect = 1; redirect_pc = 16'h0100;
    tick();
    checks++; if (imem_addr !== 16'h0020 || if_id_valid !== 1'b0)
      begin fails++; $display("[TB] FAIL redir_pending got addr=%h v=%b exp 0020 0", imem_addr, if_id_valid); end
    redirect = 0; imem_done = 1;
    tick();
    checks++; if (imem_addr !== 16'h0100 || if_id_valid !== 1'b0)
      begin fails++; $display("[TB] FAIL redir_drop got addr=%h v=%b exp 0100 0", imem_addr, if_id_valid); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc2 !== 16'h0102 || if_id_instr !== (16'h0100 ^ 16'hA5A5))
      begin fails++; $display("[TB] FAIL redir_target got v=%b pc2=%h i=%h exp 1 0102 %h", if_id_valid, if_id_pc2, if_id_instr, 16'h0100 ^ 16'hA5A5); end
  endtask

  task automatic test_redirect_stall();
    redirect = 1; reg_haz = 1; redirect_pc = 16'h0200;
    tick();
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 16'h0800 || imem_addr !== 16'h0200)
      begin fails++; $display("[TB] FAIL redir_haz got v=%b i=%h addr=%h exp 0 0800 0200", if_id_valid, if_id_instr, imem_addr); end
    redirect = 0; reg_haz = 0;
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc2 !== 16'h0202)
      begin fails++; $display("[TB] FAIL redir_haz_resume got v=%b pc2=%h exp 1 0202", if_id_valid, if_id_pc2); end
  endtask

  task automatic test_wrap();
    redirect = 1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 0;
    tick();
    checks++; if (if_id_pc2 !== 16'h0000 || if_id_instr !== 16'h5A5B || imem_addr !== 16'h0000)
      begin fails++; $display("[TB] FAIL wrap got pc2=%h i=%h addr=%h exp 0000 5a5b 0000", if_id_pc2, if_id_instr, imem_addr); end
    tick();
  endtask

  task automatic test_halt();
    halt_id = 1;
    tick();
    checks++; if (halted !== 1'b1 || imem_rd !== 1'b0 || if_id_valid !== 1'b0 || imem_addr !== 16'h0002)
      begin fails++; $display("[TB] FAIL halt got h=%b rd=%b v=%b addr=%h exp 1 0 0 0002", halted, imem_rd, if_id_valid, imem_addr); end
    halt_id = 0; redirect = 1; redirect_pc = 16'h0300;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (halted !== 1'b1 || imem_rd !== 1'b0 || if_id_valid !== 1'b0 || imem_addr !== 16'h0002)
        begin fails++; $display("[TB] FAIL halt_stay_%0d got h=%b rd=%b v=%b addr=%h", k, halted, imem_rd, if_id_valid, imem_addr); end
    end
    redirect = 0;
  endtask

  task automatic test_midrun_reset();
    rst = 1;
    tick();
    checks++; if (imem_addr !== 16'h0000 || halted !== 1'b0 || imem_rd !== 1'b1 || if_id_valid !== 1'b0)
      begin fails++; $display("[TB] FAIL rst_mid got addr=%h h=%b rd=%b v=%b exp 0000 0 1 0", imem_addr, halted, imem_rd, if_id_valid); end
    rst = 0;
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc2 !== 16'h0002 || if_id_instr !== 16'hA5A5)
      begin fails++; $display("[TB] FAIL rst_resume got v=%b pc2=%h i=%h exp 1 0002 a5a5", if_id_valid, if_id_pc2, if_id_instr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_wait_mem();
    test_redirect_wait();
    test_redirect_stall();
    test_wrap();
    test_halt();
    test_midrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
